// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: register map, IntCtrl fields,
// FSM state encoding, interrupt source indices and a priority helper.
package interrupt_controller_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [31:0] OFF_INT_CTRL    = 32'h0;
  localparam logic [31:0] OFF_INT_PENDING = 32'h4;
  localparam logic [31:0] OFF_INT_CAUSE   = 32'h8;

  localparam int CTRL_GIE_BIT    = 4;
  localparam int CTRL_MASK_MSB   = 3;
  localparam int CAUSE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    SRC_TIMER   = 2'd0,
    SRC_UART_RX = 2'd1,
    SRC_UART_TX = 2'd2,
    SRC_EXT     = 2'd3
  } irq_src_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Lowest-numbered active source has the highest priority.
  function automatic irq_src_e lowest_src(input logic [NUM_SRC-1:0] active);
    irq_src_e src;
    src = SRC_TIMER;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) src = irq_src_e'(2'(i));
    end
    return src;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line, followed by a
// rising-edge detector on the synchronized level.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_fill;

  // r_prev starts high and only tracks r_sync once the chain holds real
  // samples, so a line already high at reset release is not seen as an edge.
  // NOTE: non-blocking (<=) for every flop so each stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b1;
      r_fill <= 2'b00;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1]) r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: four level sources latched into pending
// bits, masked and prioritised, with a three-state trap handshake to the CPU.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  IntReq,
  input  logic        PCSupervisor,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam logic [31:0] ADDR_CTRL    = BASE_ADDR + OFF_INT_CTRL;
  localparam logic [31:0] ADDR_PENDING = BASE_ADDR + OFF_INT_PENDING;
  localparam logic [31:0] ADDR_CAUSE   = BASE_ADDR + OFF_INT_CAUSE;

  irq_state_e         r_state;
  irq_state_e         w_state_next;
  logic               r_gie;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  irq_src_e           r_cause_idx;
  logic               r_cause_valid;
  logic               r_sup_seen;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_clear;
  logic               w_sel_ctrl;
  logic               w_sel_pend;
  logic               w_sel_cause;
  logic               w_hit;
  logic               w_take_trap;
  logic [31:0]        w_read_data;
  logic               w_unused;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync u_edge_sync (
      .clk    (clk),
      .reset  (reset),
      .i_async(IntReq[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_sel_ctrl  = (Address[31:2] == ADDR_CTRL[31:2]);
  assign w_sel_pend  = (Address[31:2] == ADDR_PENDING[31:2]);
  assign w_sel_cause = (Address[31:2] == ADDR_CAUSE[31:2]);
  assign w_clear     = (MemWr && w_sel_pend) ? WriteData[NUM_SRC-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gie     <= 1'b0;
      r_mask    <= '0;
      r_pending <= '0;
    end else begin
      if (MemWr && w_sel_ctrl) begin
        r_gie  <= WriteData[CTRL_GIE_BIT];
        r_mask <= WriteData[CTRL_MASK_MSB:0];
      end
      // A new edge wins over a software clear landing in the same cycle.
      r_pending <= (r_pending & ~w_clear) | w_rise;
    end
  end

  assign w_active    = r_pending & r_mask;
  assign w_hit       = r_gie & (|w_active);
  assign IRQ         = (r_state == ST_PENDING) & ~PCSupervisor;
  assign w_take_trap = IRQ;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: default assigned first so every path drives w_state_next (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_hit) w_state_next = ST_PENDING;
      ST_PENDING: begin
        if (w_take_trap) w_state_next = ST_SERVICE;
        else if (!w_hit) w_state_next = ST_IDLE;
      end
      ST_SERVICE: if (!PCSupervisor && r_sup_seen) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Cause persists across the handler; r_sup_seen marks handler entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cause_idx   <= SRC_TIMER;
      r_cause_valid <= 1'b0;
      r_sup_seen    <= 1'b0;
    end else begin
      if (w_take_trap) begin
        r_cause_idx   <= lowest_src(w_active);
        r_cause_valid <= 1'b1;
      end
      if (r_state != ST_SERVICE) r_sup_seen <= 1'b0;
      else if (PCSupervisor)     r_sup_seen <= 1'b1;
    end
  end

  always_comb begin
    w_read_data = '0;
    if (MemRd) begin
      if (w_sel_ctrl) begin
        w_read_data[CTRL_GIE_BIT]      = r_gie;
        w_read_data[CTRL_MASK_MSB:0]   = r_mask;
      end else if (w_sel_pend) begin
        w_read_data[NUM_SRC-1:0]       = r_pending;
      end else if (w_sel_cause) begin
        w_read_data[CAUSE_VALID_BIT]   = r_cause_valid;
        w_read_data[1:0]               = r_cause_idx;
      end
    end
  end

  assign ReadData = w_read_data;
  assign w_unused = ^{Address[1:0], WriteData[31:CTRL_GIE_BIT+1]};

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios, then randomized traffic,
// every cycle compared against a behavioural model of the register/trap rules.
module tb_interrupt_controller;

  localparam logic [31:0] BASE    = 32'h40000030;
  localparam logic [31:0] A_CTRL  = BASE;
  localparam logic [31:0] A_PEND  = BASE + 32'h4;
  localparam logic [31:0] A_CAUSE = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  IntReq;
  logic        PCSupervisor;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IRQ;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_controller #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .IntReq      (IntReq),
    .PCSupervisor(PCSupervisor),
    .MemRd       (MemRd),
    .MemWr       (MemWr),
    .Address     (Address),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .IRQ         (IRQ)
  );

  always #5 clk = ~clk;

  // Behavioural model: phases of the trap handshake and software-visible registers.
  typedef enum {PH_IDLE, PH_WAIT, PH_HANDLER} phase_e;
  phase_e     m_phase;
  logic       m_gie;
  logic [3:0] m_mask;
  logic [3:0] m_pend;
  logic [1:0] m_cause;
  logic       m_cause_v;
  logic       m_sup_seen;
  logic [3:0] h1, h2, h3;   // IntReq sampled 1, 2 and 3 edges ago
  int         high_run;     // consecutive edges with reset released

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase    = PH_IDLE;
    m_gie      = 1'b0;
    m_mask     = 4'h0;
    m_pend     = 4'h0;
    m_cause    = 2'd0;
    m_cause_v  = 1'b0;
    m_sup_seen = 1'b0;
    high_run   = 0;
  endtask

  function automatic logic model_irq();
    return (m_phase == PH_WAIT) && !PCSupervisor;
  endfunction

  function automatic logic [31:0] model_rdata();
    logic [31:0] word;
    word = Address & ~32'h3;
    if (!MemRd)          return 32'h0;
    if (word == A_CTRL)  return {27'b0, m_gie, m_mask};
    if (word == A_PEND)  return {28'b0, m_pend};
    if (word == A_CAUSE) return {m_cause_v, 29'b0, m_cause};
    return 32'h0;
  endfunction

  task automatic update_model();
    logic [3:0]  rise, act, w1c;
    logic [31:0] word;
    logic        hit;
    int          idx;
    if (!reset) begin
      model_reset();
    end else begin
      high_run++;
      // A source counts as rising only when both samples postdate reset release.
      rise = (high_run >= 4) ? (h2 & ~h3) : 4'h0;
      act  = m_pend & m_mask;
      hit  = m_gie && (act != 4'h0);
      case (m_phase)
        PH_IDLE: if (hit) m_phase = PH_WAIT;
        PH_WAIT: begin
          if (!PCSupervisor) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (act[i]) begin idx = i; break; end
            m_cause    = 2'(idx);
            m_cause_v  = 1'b1;
            m_sup_seen = 1'b0;
            m_phase    = PH_HANDLER;
          end else if (!hit) begin
            m_phase = PH_IDLE;
          end
        end
        default: begin
          if (PCSupervisor)    m_sup_seen = 1'b1;
          else if (m_sup_seen) m_phase = PH_IDLE;
        end
      endcase
      word = Address & ~32'h3;
      w1c  = 4'h0;
      if (MemWr && word == A_CTRL) {m_gie, m_mask} = WriteData[4:0];
      if (MemWr && word == A_PEND) w1c = WriteData[3:0];
      m_pend = (m_pend & ~w1c) | rise;
    end
    h3 = h2;
    h2 = h1;
    h1 = IntReq;
  endtask

  // One clock: compare combinational outputs mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    check("irq", {31'b0, IRQ}, {31'b0, model_irq()});
    check("rdata", ReadData, model_rdata());
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemWr = 1'b1; Address = addr; WriteData = data;
    step();
    MemWr = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MemRd = 1'b1; Address = addr;
    #1;
    check(tag, ReadData, exp);
    step();
    MemRd = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int waited;
    waited = 0;
    #1;
    while (IRQ !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    check(tag, {31'b0, IRQ}, 32'h1);
  endtask

  task automatic handler_return(input logic [3:0] clr);
    PCSupervisor = 1'b1;
    step();
    wr(A_PEND, {28'b0, clr});
    PCSupervisor = 1'b0;
    step();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(5))
      0:       a = A_CTRL;
      1:       a = A_PEND;
      2:       a = A_CAUSE;
      3:       a = BASE + 32'hC;
      4:       a = BASE - 32'h4;
      default: a = $urandom;
    endcase
    return a | 32'($urandom_range(3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; IntReq = 4'h0; PCSupervisor = 1'b0;
    MemRd = 1'b0; MemWr = 1'b0; Address = 32'h0; WriteData = 32'h0;
    h1 = 4'h0; h2 = 4'h0; h3 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;

    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_rdata_idle", ReadData, 32'h0);
    rd_check("rst_ctrl", A_CTRL, 32'h0);
    rd_check("rst_pend", A_PEND, 32'h0);
    rd_check("rst_cause", A_CAUSE, 32'h0);

    // Single UART tx pulse, all enabled.
    wr(A_CTRL, 32'h1F);
    IntReq = 4'b0100; step(); step(); IntReq = 4'b0000; step();
    rd_check("t1_pend", A_PEND, 32'h4);
    check("t1_irq", {31'b0, IRQ}, 32'h1);
    step();
    rd_check("t1_cause", A_CAUSE, 32'h80000002);
    handler_return(4'h4);

    // Two simultaneous sources are served lowest index first.
    IntReq = 4'b1010; step(); step(); IntReq = 4'b0000; step();
    rd_check("t2_pend", A_PEND, 32'hA);
    check("t2_irq", {31'b0, IRQ}, 32'h1);
    step();
    rd_check("t2_cause1", A_CAUSE, 32'h80000001);
    handler_return(4'h2);
    wait_irq("t2_irq2", 4);
    step();
    rd_check("t2_cause2", A_CAUSE, 32'h80000003);
    handler_return(4'h8);

    // Global enable off holds the request back until GIE is written.
    wr(A_CTRL, 32'h0F);
    IntReq = 4'b0001; step(); step(); IntReq = 4'b0000; step();
    rd_check("t3_pend", A_PEND, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t3_irq_gated", {31'b0, IRQ}, 32'h0);
      step();
    end
    wr(A_CTRL, 32'h11);
    step();
    check("t3_irq_on", {31'b0, IRQ}, 32'h1);
    step();
    handler_return(4'h1);

    // Supervisor code in flight masks IRQ; it appears the cycle it drops.
    wr(A_CTRL, 32'h1F);
    PCSupervisor = 1'b1;
    IntReq = 4'b0010; step(); step(); IntReq = 4'b0000; step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_irq_sup", {31'b0, IRQ}, 32'h0);
      step();
    end
    PCSupervisor = 1'b0;
    #1;
    check("t4_irq_drop", {31'b0, IRQ}, 32'h1);
    step();
    rd_check("t4_cause", A_CAUSE, 32'h80000001);
    handler_return(4'h2);

    // Clear landing on the same edge as a new set keeps the bit.
    wr(A_CTRL, 32'h00);
    IntReq = 4'b0001; step(); step(); IntReq = 4'b0000; step(); step(); step();
    rd_check("t5_pend_pre", A_PEND, 32'h1);
    IntReq = 4'b0001; step(); step();
    wr(A_PEND, 32'h1);
    rd_check("t5_pend_keep", A_PEND, 32'h1);
    wr(A_PEND, 32'h1);
    rd_check("t5_pend_clr", A_PEND, 32'h0);
    IntReq = 4'b0000; step(); step(); step();

    // Reset mid-handler with the external line held high.
    wr(A_CTRL, 32'h1F);
    IntReq = 4'b1000;
    wait_irq("t6_irq_pre", 8);
    step();
    PCSupervisor = 1'b1; step();
    reset = 1'b0; step(); reset = 1'b1;
    PCSupervisor = 1'b0;
    rd_check("t6_ctrl", A_CTRL, 32'h0);
    rd_check("t6_pend", A_PEND, 32'h0);
    rd_check("t6_cause", A_CAUSE, 32'h0);
    wr(A_CTRL, 32'h1F);
    for (int i = 0; i < 8; i++) begin
      check("t6_irq_held", {31'b0, IRQ}, 32'h0);
      step();
    end
    rd_check("t6_pend_held", A_PEND, 32'h0);
    IntReq = 4'b0000; step(); step(); step();
    IntReq = 4'b1000;
    wait_irq("t6_irq_retoggle", 8);
    step();
    IntReq = 4'b0000;
    handler_return(4'h8);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) IntReq[b] = ~IntReq[b];
      end
      PCSupervisor = 1'($urandom_range(1));
      reset        = ($urandom_range(199) != 0);
      MemWr        = ($urandom_range(5) == 0);
      MemRd        = ($urandom_range(2) == 0);
      Address      = pick_addr();
      WriteData    = $urandom;
      step();
    end
    reset = 1'b1; MemWr = 1'b0; MemRd = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h40000030, byte address of the first of three register words.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port IntReq, input, 4, level interrupt sources [0]=timer, [1]=UART rx, [2]=UART tx, [3]=external; asynchronous to clk.
REQ-005 SHALL have port PCSupervisor, input, 1, supervisor bit (PC[31]) of the instruction in the current cycle.
REQ-006 SHALL have port MemRd, input, 1, bus read strobe.
REQ-007 SHALL have port MemWr, input, 1, bus write strobe.
REQ-008 SHALL have port Address, input, 32, bus byte address.
REQ-009 SHALL have port WriteData, input, 32, bus write data.
REQ-010 SHALL have port ReadData, output, 32, register read data; 0 when not selected.
REQ-011 SHALL have port IRQ, output, 1, interrupt request to the CPU controller.

Function
REQ-012 Register map: BASE+0 IntCtrl (RW: bit4 GIE, bits3:0 Mask); BASE+4 IntPending (bits3:0, read; write-1-to-clear); BASE+8 IntCause (RO: bits1:0 index, bit31 valid); unused bits read 0.
REQ-013 Each IntReq bit SHALL pass a 2-flop synchronizer; a 0->1 transition at the synchronizer output SHALL set its pending bit one cycle later (3-cycle latency from input change to pending).
REQ-014 Same-cycle set and write-1-clear of one pending bit SHALL leave it set.
REQ-015 Writes SHALL take effect at the clock edge of the cycle MemWr=1 with a matching word address (Address[1:0] ignored); writes to BASE+8 ignored.
REQ-016 Reads SHALL be combinational: ReadData valid in the same cycle MemRd=1 with a matching address; else 32'h0.
REQ-017 FSM states IDLE, PENDING, SERVICE; encoding 2 bits.
REQ-018 IDLE->PENDING when GIE=1 and (Pending & Mask)!=0.
REQ-019 PENDING->IDLE if the condition of REQ-018 becomes false before the trap is taken.
REQ-020 IRQ = (state==PENDING) & ~PCSupervisor, combinational; IRQ SHALL never assert in IDLE or SERVICE.
REQ-021 In a cycle with IRQ=1 (trap taken) the FSM SHALL go to SERVICE and latch IntCause = index of lowest-numbered set bit of (Pending & Mask), valid=1.
REQ-022 SERVICE->IDLE on the first cycle PCSupervisor=0 after at least one cycle of PCSupervisor=1 in SERVICE (return from handler); IntCause SHALL hold until the next trap.
REQ-023 Pending bits are not cleared by hardware; software SHALL clear them, else IDLE re-enters PENDING the next cycle.
REQ-024 Mask or GIE writes during SERVICE SHALL not alter state; they apply at re-evaluation in IDLE.

Reset
REQ-025 reset=0 at a clock edge SHALL force: state IDLE, IntCtrl 0, Pending 0, IntCause 0, synchronizers 0; IRQ=0, ReadData=0 with no MemRd.
REQ-026 Reset mid-SERVICE or mid-PENDING SHALL discard all state; no IRQ for a source held high through reset until it falls and rises again.

Structure
REQ-027 Register offsets, IntCtrl bit positions, state encodings and source indices SHALL live in the shared CPU constants header.
REQ-028 One sub-module irq_edge_sync (2-flop sync + rising-edge detect, 1 bit) SHALL be instanced 4 times.

Verification
REQ-029 IntCtrl=0x1F, pulse IntReq[2] -> Pending=0x4 after 3 cycles, IRQ=1 next cycle with PCSupervisor=0, IntCause reads 0x80000002.
REQ-030 IntReq=4'b1010 simultaneously, Mask all -> IntCause index 1; after W1C 0x2 and return, second trap with index 3.
REQ-031 GIE=0, pulse IntReq[0] -> Pending=0x1, IRQ stays 0; write IntCtrl=0x11 -> IRQ=1 within 2 cycles.
REQ-032 PENDING with PCSupervisor=1 held 5 cycles -> IRQ=0 throughout; PCSupervisor drops -> IRQ=1 same cycle.
REQ-033 W1C 0x1 in same cycle as new set of bit 0 -> bit 0 remains 1.
REQ-034 reset=0 during SERVICE with IntReq[3] held high -> all registers 0, IRQ=0 after release until IntReq[3] toggles.
